// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
//   fetch_state_t  : FETCH (issuing allowed) / HALTED (drain only)
//   fetch_packet_t : {pc, inst} record pushed into the instruction buffer
//   INST_BYTES     : PC step per sequential fetch
//   word_align()   : clears the byte-offset bits of a fetch address
package fetch_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_packet_t;

  localparam int unsigned INST_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_queue.sv
// In-order PC FIFO: remembers the PC of every outstanding memory request so
// each in-order response can be paired with its address.
//   clock, reset : system clock, synchronous active-high reset (empties queue)
//   push/push_pc : enqueue the PC of an accepted request
//   pop          : dequeue the head (one response consumed)
//   head_pc      : PC at the head, read straight from the storage registers
//   empty/full   : occupancy flags
// A push into a full queue is only accepted when a pop frees a slot in the
// same cycle; a pop of an empty queue is ignored.
module fetch_pc_queue #(
  parameter int DEPTH = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic        pop,
  output logic [31:0] head_pc,
  output logic        empty,
  output logic        full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][31:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   do_push, do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_pc = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_pc;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: generates sequential word-aligned PCs, issues in-order
// instruction-memory reads and pushes {pc, inst} packets into the
// instruction buffer FIFO. The FIFO's free-slot count is used as credit so a
// live response can always be written the cycle it arrives. A redirect turns
// every outstanding request stale; stale responses are dropped.
// Optional: define FETCH_PERF_EN to add saturating perf counters.
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   redirect_valid/_pc  : squash in-flight work and restart at redirect_pc
//   halt                : stop issuing until the next redirect
//   req_valid/addr/ready: memory read request handshake
//   rsp_valid/rsp_data  : in-order memory response
//   fifo_wr_en/_data    : packet write into the FIFO ({pc, inst})
//   fifo_wr_valid       : FIFO accepted the write
//   fifo_spots          : FIFO free slots (credit)
//   perf_credit_stall   : (FETCH_PERF_EN) cycles blocked only by credit
//   perf_squashed       : (FETCH_PERF_EN) stale responses dropped
//   fetching            : high while in FETCH state
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 3,
  parameter int          MAX_CNT         = 3,
  localparam int         CNT_BITS        = $clog2(MAX_CNT + 1),
  localparam int         OUT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  input  logic                halt,
  output logic                req_valid,
  output logic [31:0]         req_addr,
  input  logic                req_ready,
  input  logic                rsp_valid,
  input  logic [31:0]         rsp_data,
  output logic                fifo_wr_en,
  output logic [63:0]         fifo_wr_data,
  input  logic                fifo_wr_valid,
  input  logic [CNT_BITS-1:0] fifo_spots,
`ifdef FETCH_PERF_EN
  output logic [31:0]         perf_credit_stall,
  output logic [31:0]         perf_squashed,
`endif
  output logic                fetching
);

  fetch_state_t        state, state_nxt;
  logic [31:0]         pc;
  logic [OUT_BITS-1:0] live_cnt, stale_cnt;
  logic [OUT_BITS:0]   total;
  logic                room, credit, issue;
  logic                rsp_drop, rsp_live;
  logic [31:0]         head_pc;
  logic                q_empty, q_full;
  fetch_packet_t       pkt;

  assign total  = {1'b0, live_cnt} + {1'b0, stale_cnt};
  assign room   = total < (OUT_BITS + 1)'(MAX_OUTSTANDING);
  // Credit: every live request owns a FIFO slot, so its response can never
  // be refused.
  assign credit = 32'(live_cnt) < 32'(fifo_spots);

  assign req_valid = !reset && (state == FETCH) && !redirect_valid && room && credit;
  assign req_addr  = reset ? '0 : pc;
  assign issue     = req_valid && req_ready;

  // A response landing in the redirect cycle belongs to the old path.
  assign rsp_drop = rsp_valid && ((stale_cnt != '0) || redirect_valid);
  assign rsp_live = rsp_valid && !rsp_drop;

  assign pkt          = '{pc: head_pc, inst: rsp_data};
  assign fifo_wr_en   = !reset && rsp_live;
  assign fifo_wr_data = reset ? '0 : pkt;

  fetch_pc_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clock   (clock),
    .reset   (reset),
    .push    (issue),
    .push_pc (pc),
    .pop     (rsp_valid),
    .head_pc (head_pc),
    .empty   (q_empty),
    .full    (q_full)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fetching  = reset || (state == FETCH);
    if (redirect_valid)                 state_nxt = FETCH;
    else if (state == FETCH && halt)    state_nxt = HALTED;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      live_cnt  <= '0;
      stale_cnt <= '0;
    end else if (redirect_valid) begin
      pc        <= word_align(redirect_pc);
      live_cnt  <= '0;
      stale_cnt <= stale_cnt + live_cnt - OUT_BITS'(rsp_valid);
    end else begin
      if (issue) pc <= pc + 32'(INST_BYTES);
      live_cnt  <= live_cnt + OUT_BITS'(issue) - OUT_BITS'(rsp_live);
      stale_cnt <= stale_cnt - OUT_BITS'(rsp_drop);
    end
  end

`ifdef FETCH_PERF_EN
  logic credit_stall;
  assign credit_stall = (state == FETCH) && !redirect_valid && room && !credit;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_credit_stall <= '0;
      perf_squashed     <= '0;
    end else begin
      if (credit_stall && perf_credit_stall != '1) perf_credit_stall <= perf_credit_stall + 32'd1;
      if (rsp_drop && perf_squashed != '1)         perf_squashed     <= perf_squashed + 32'd1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(fifo_wr_en && !fifo_wr_valid));
      assert (!(rsp_valid && total == '0));
      assert (!(rsp_valid && q_empty));
      assert (!(issue && q_full && !rsp_valid));
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int CNT_BITS = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                redirect_valid = 1'b0;
  logic [31:0]         redirect_pc = '0;
  logic                halt = 1'b0;
  logic                req_valid;
  logic [31:0]         req_addr;
  logic                req_ready = 1'b0;
  logic                rsp_valid = 1'b0;
  logic [31:0]         rsp_data = '0;
  logic                fifo_wr_en;
  logic [63:0]         fifo_wr_data;
  logic                fifo_wr_valid = 1'b1;
  logic [CNT_BITS-1:0] fifo_spots = 2'd3;
  logic                fetching;
`ifdef FETCH_PERF_EN
  logic [31:0]         perf_credit_stall, perf_squashed;
  logic [31:0]         m_stall, m_squash;
`endif

  always #5 clock = ~clock;

  fetch_ctrl #(.RESET_PC(RST_PC), .MAX_OUTSTANDING(3), .MAX_CNT(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_wr_data   (fifo_wr_data),
    .fifo_wr_valid  (fifo_wr_valid),
    .fifo_spots     (fifo_spots),
`ifdef FETCH_PERF_EN
    .perf_credit_stall (perf_credit_stall),
    .perf_squashed     (perf_squashed),
`endif
    .fetching       (fetching)
  );

  // Reference model: memory holds tagged requests; a redirect bumps the
  // epoch, and only responses whose epoch is current get written.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] m_pc;
  bit          m_halted;
  int          m_epoch, fcount, cyc;
  int          n_checks = 0, n_pass = 0;

  // knobs
  int p_redirect, p_halt, p_ready, p_drain, lat_min, lat_max, cap;
  bit force_redir, force_halt;
  logic [31:0] force_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      reset          = 1'b1;
      redirect_valid = 1'($urandom);
      redirect_pc    = $urandom;
      halt           = 1'($urandom);
      req_ready      = 1'($urandom);
      rsp_valid      = 1'($urandom);
      rsp_data       = $urandom;
      fifo_wr_valid  = 1'b1;
      fifo_spots     = 2'd3;
      @(negedge clock);
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_req_addr", 64'(req_addr), 64'd0);
      chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
      chk("rst_fetching", 64'(fetching), 64'd1);
    end
    mem_q.delete();
    m_pc = RST_PC; m_halted = 0; m_epoch = 0; fcount = 0;
`ifdef FETCH_PERF_EN
    m_stall = 0; m_squash = 0;
`endif
  endtask

  task automatic run_cycles(input int n);
    int sp, live, total, lat;
    bit exp_req, exp_wr;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      cyc++;
      reset = 1'b0;
      if (force_redir) begin
        redirect_valid = 1'b1; redirect_pc = force_pc; force_redir = 0;
      end else begin
        redirect_valid = ($urandom_range(99) < p_redirect);
        redirect_pc    = $urandom;
      end
      halt      = force_halt || ($urandom_range(99) < p_halt);
      force_halt = 0;
      req_ready = ($urandom_range(99) < p_ready);
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
      if (mem_q.size() > 0) begin
        if (mem_q[0].ready <= cyc) begin
          rsp_valid = 1'b1;
          rsp_data  = inst_of(mem_q[0].addr);
        end
      end
      sp = 3 - fcount;
      if (sp > cap) sp = cap;
      fifo_spots    = CNT_BITS'(sp);
      fifo_wr_valid = (fcount < 3);

      @(negedge clock);
      live = 0;
      foreach (mem_q[k]) if (mem_q[k].epoch == m_epoch) live++;
      total   = mem_q.size();
      exp_req = !m_halted && !redirect_valid && total < 3 && live < sp;
      exp_wr  = rsp_valid && mem_q[0].epoch == m_epoch && !redirect_valid;

      chk("fetching", 64'(fetching), 64'(!m_halted));
      chk("req_valid", 64'(req_valid), 64'(exp_req));
      if (exp_req) chk("req_addr", 64'(req_addr), 64'(m_pc));
      chk("fifo_wr_en", 64'(fifo_wr_en), 64'(exp_wr));
      if (exp_wr) chk("fifo_wr_data", fifo_wr_data, {mem_q[0].addr, inst_of(mem_q[0].addr)});
`ifdef FETCH_PERF_EN
      chk("perf_credit_stall", 64'(perf_credit_stall), 64'(m_stall));
      chk("perf_squashed", 64'(perf_squashed), 64'(m_squash));
      if (!m_halted && !redirect_valid && total < 3 && live >= sp) m_stall++;
      if (rsp_valid && !exp_wr) m_squash++;
`endif

      if (rsp_valid) void'(mem_q.pop_front());
      if (exp_wr) fcount++;
      if (exp_req && req_ready) begin
        lat = $urandom_range(lat_max, lat_min);
        mem_q.push_back('{addr: m_pc, epoch: m_epoch, ready: cyc + lat});
        m_pc = m_pc + 32'd4;
      end
      if (redirect_valid) begin
        m_epoch++;
        m_pc     = {redirect_pc[31:2], 2'b00};
        m_halted = 0;
      end else if (halt) begin
        m_halted = 1;
      end
      if (fcount > 0 && $urandom_range(99) < p_drain) fcount--;
    end
  endtask

  initial begin
    cyc = 0; force_redir = 0; force_halt = 0; force_pc = '0;
    p_redirect = 0; p_halt = 0; p_ready = 100; p_drain = 100;
    lat_min = 1; lat_max = 1; cap = 3;
    do_reset(2);

    // streaming, 1-cycle memory
    run_cycles(20);
    // one credit, slow memory
    cap = 1; lat_min = 4; lat_max = 4;
    run_cycles(40);
    // redirect with requests in flight
    cap = 3; lat_min = 3; lat_max = 3;
    run_cycles(6);
    force_redir = 1; force_pc = 32'h0000_0203;
    run_cycles(30);
    // halt, then resume via redirect
    lat_min = 2; lat_max = 2;
    run_cycles(3);
    force_halt = 1;
    run_cycles(10);
    force_redir = 1; force_pc = 32'h0000_0040;
    run_cycles(10);
    // PC wrap
    lat_min = 1; lat_max = 1;
    force_redir = 1; force_pc = 32'hFFFF_FFFE;
    run_cycles(10);
    // no credit at all
    cap = 0;
    run_cycles(10);

    // randomized traffic
    p_redirect = 8; p_halt = 4; p_ready = 60; p_drain = 50;
    lat_min = 1; lat_max = 5;
    for (int c = 0; c < 40; c++) begin
      cap = $urandom_range(3);
      run_cycles(50);
    end
    // reset in the middle of traffic
    do_reset(3);
    cap = 3;
    run_cycles(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Upstream feeder of the instruction-buffer FIFO (WIDTH=64, MAX_CNT=3) between fetch and decode.
- Generates sequential PCs and issues in-order instruction-memory reads.
- Pushes {pc, inst} packets into the FIFO, one per cycle.
- Uses the FIFO's `spots` output as credit so every response can always be written; drops responses squashed by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MAX_OUTSTANDING, 3, max memory requests in flight (live + stale).
- MAX_CNT, 3, must equal the downstream FIFO's MAX_CNT.
- CNT_BITS, $clog2(MAX_CNT+1), width of spots (localparam).
- OUT_BITS, $clog2(MAX_OUTSTANDING+1), in-flight counter width (localparam).

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  squash and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored.
- halt  in  1  stop issuing new requests until the next redirect.
- req_valid  out  1  memory read request.
- req_addr  out  32  word-aligned fetch address.
- req_ready  in  1  memory accepts the request this cycle.
- rsp_valid  in  1  memory response; in order, ≥1 cycle after acceptance.
- rsp_data  in  32  instruction word.
- fifo_wr_en  out  1  to FIFO wr_en.
- fifo_wr_data  out  64  {pc[63:32], inst[31:0]}.
- fifo_wr_valid  in  1  FIFO wr_valid (accepted).
- fifo_spots  in  CNT_BITS  FIFO free-slot count, capped at MAX_CNT.
- fetching  out  1  high in FETCH state.

Behaviour:
- Reset values:
  - state=FETCH, pc=RESET_PC.
  - live_cnt=0, stale_cnt=0.
  - Tag-PC queue empty.
  - All outputs 0 except fetching=1; reset dominates all inputs.
- States:
  - FETCH: issuing allowed.
  - HALTED: no issue; responses still processed.
  - FETCH→HALTED on halt && !redirect_valid.
  - Any state→FETCH on redirect_valid (redirect wins over halt in the same cycle).
- Issue rule: req_valid = state==FETCH && !redirect_valid && (live_cnt+stale_cnt) < MAX_OUTSTANDING && live_cnt < fifo_spots.
  - req_addr = pc.
  - On req_valid && req_ready: push pc into the in-order PC queue (depth MAX_OUTSTANDING); pc <= pc+4 (32-bit wrap); live_cnt++.
- Response rule:
  - If stale_cnt>0: the response is dropped, stale_cnt--, and the PC-queue head is popped.
  - Else: fifo_wr_en=1 in the same cycle; fifo_wr_data={queue head pc, rsp_data}; pop; live_cnt--.
  - Combinational path rsp→fifo_wr_en (zero latency).
- Credit invariant: live_cnt ≤ fifo_spots at issue time. A live response is therefore never refused. fifo_wr_en && !fifo_wr_valid is an assertion failure.
- Redirect cycle:
  - pc <= {redirect_pc[31:2],2'b0}.
  - stale_cnt <= stale_cnt + live_cnt, minus 1 if a response arrives that cycle. That response is treated as stale and dropped, with no FIFO write.
  - live_cnt <= 0.
  - No issue in the redirect cycle.
  - Responses arriving after a redirect with stale_cnt==0 belong to new-path requests.
- Simultaneous issue+response: counters net out (live_cnt unchanged). PC queue push and pop happen in the same cycle.
- rsp_valid with zero total in-flight is an assertion failure.
- Reset mid-operation discards all in-flight state. Memory is also reset by the same signal.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_credit_stall[31:0] and perf_squashed[31:0].
  - perf_credit_stall: cycles in FETCH with !redirect_valid where issue was blocked only by live_cnt≥fifo_spots.
  - perf_squashed: stale responses dropped.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; identical functional behaviour.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {FETCH, HALTED}.
  - fetch_packet_t struct {logic [31:0] pc; logic [31:0] inst;}.
  - Constant INST_BYTES=4.
- One sub-module: fetch_pc_queue, a small in-order PC FIFO (depth MAX_OUTSTANDING, push/pop, registered head output).
- Counters, FSM and credit logic stay in fetch_ctrl.

Test Plan:
- Reset with RESET_PC=0x100, req_ready=1, fifo_spots=3, 1-cycle memory → requests to 0x100, 0x104, 0x108. FIFO writes {0x100,inst0},{0x104,inst1}… in order.
- fifo_spots held at 1, memory latency 4 → at most one live request. req_valid low for 4 cycles between requests; no refused write.
- 3 requests in flight, redirect_pc=0x203 → next req_addr=0x200. Exactly 3 responses dropped (no fifo_wr_en). 4th response written with pc=0x200.
- Redirect in the same cycle as a response with 2 in flight → that response dropped, stale_cnt=1. Next response also dropped. Third response written.
- halt asserted with 1 in flight → no new req_valid, fetching=0. The in-flight response is still written. Redirect to 0x40 resumes fetching at 0x40.
- pc=0xFFFF_FFFC → next request address 0x0000_0000 (wrap). With FETCH_PERF_EN, a credit-blocked cycle increments perf_credit_stall by 1.
